// File: rtl/board_io_pkg.sv
// Shared definitions for board_io_cond: counter sizing, default timing and the
// reset-generator state type.
package board_io_pkg;

    // Width of a counter that has to hold values 0..n (never narrower than 1 bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Debounce window of 10 ms expressed in clock cycles for a given clock frequency
    function automatic int unsigned debounce_cycles_for(input int unsigned clk_mhz);
        return clk_mhz * 10000;
    endfunction

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = debounce_cycles_for(100);
    localparam int unsigned DEFAULT_RST_HOLD_CYCLES = 16;
    localparam int unsigned DEBOUNCE_CNT_W          = cnt_width(DEFAULT_DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_CNT_W              = cnt_width(DEFAULT_RST_HOLD_CYCLES);

    typedef enum logic {
        RST_ASSERTED,
        RST_RELEASED
    } rst_state_t;

endpackage

// File: rtl/board_io_cond_debounce_ch.sv
// One input channel: synchroniser, stability counter and accepted level.
// With FILTER=0 the channel is a plain synchroniser and never pulses.
module debounce_ch
    import board_io_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          FILTER          = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int unsigned    CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    // Bring the asynchronous input into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], din};
    end

    generate
        if (FILTER) begin : g_filter
            logic [CW-1:0] cnt;
            logic          stable;
            logic          pulse;

            // Accept a new level only after it differed from the stable one for
            // DEBOUNCE_CYCLES consecutive samples; the rise pulse is registered
            // alongside the level so both change on the same edge
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt    <= '0;
                    stable <= 1'b0;
                    pulse  <= 1'b0;
                end else begin
                    pulse <= 1'b0;
                    if (synced == stable) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        stable <= synced;
                        pulse  <= synced;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end

            assign level = stable;
            assign rise  = pulse;
        end else begin : g_bypass
            assign level = synced;
            assign rise  = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/board_io_cond.sv
// Board I/O conditioning: PLL-lock-qualified core reset, debounced buttons and
// switches, and sticky maskable write-1-to-clear button interrupts.
module board_io_cond
    import board_io_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 5,
    parameter int unsigned NUM_SW          = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          SW_DEBOUNCE     = 1'b1,
    parameter int unsigned RST_HOLD_CYCLES = DEFAULT_RST_HOLD_CYCLES
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               pll_locked_i,
    input  logic [NUM_BTN-1:0] btn_i,
    input  logic [NUM_SW-1:0]  sw_i,
    input  logic [NUM_BTN-1:0] irq_mask_i,
    input  logic [NUM_BTN-1:0] irq_ack_i,
    output logic               srst_o,
    output logic [NUM_BTN-1:0] btn_level_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    output logic [NUM_BTN-1:0] irq_pending_o,
    output logic               irq_o,
    output logic [NUM_SW-1:0]  sw_o
);

    localparam int unsigned   HW        = cnt_width(RST_HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   lock;
    rst_state_t             rst_state;
    logic [HW-1:0]          hold_cnt;
    logic [NUM_SW-1:0]      sw_rise_unused;

    assign lock = lock_sync[SYNC_STAGES-1];

    // Synchronise PLL lock into the clock domain
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) lock_sync <= '0;
        else        lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked_i};
    end

    // Hold the core in reset until lock has been stable for RST_HOLD_CYCLES;
    // any lost lock sample re-asserts reset and restarts the hold period
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rst_state <= RST_ASSERTED;
            hold_cnt  <= '0;
            srst_o    <= 1'b1;
        end else if (!lock) begin
            rst_state <= RST_ASSERTED;
            hold_cnt  <= '0;
            srst_o    <= 1'b1;
        end else begin
            case (rst_state)
                RST_ASSERTED: begin
                    if (hold_cnt == HOLD_LAST) begin
                        rst_state <= RST_RELEASED;
                        hold_cnt  <= '0;
                        srst_o    <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                RST_RELEASED: srst_o <= 1'b0;
                default: begin
                    rst_state <= RST_ASSERTED;
                    srst_o    <= 1'b1;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            debounce_ch #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .FILTER         (1'b1)
            ) u_ch (
                .clk  (clk_i),
                .rst  (arst_i),
                .din  (btn_i[gi]),
                .level(btn_level_o[gi]),
                .rise (btn_press_o[gi])
            );
        end
        for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
            debounce_ch #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .FILTER         (SW_DEBOUNCE)
            ) u_ch (
                .clk  (clk_i),
                .rst  (arst_i),
                .din  (sw_i[gi]),
                .level(sw_o[gi]),
                .rise (sw_rise_unused[gi])
            );
        end
    endgenerate

    // Sticky press flags; a press in the same cycle as its ack keeps the bit set
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) irq_pending_o <= '0;
        else        irq_pending_o <= (irq_pending_o & ~irq_ack_i) | btn_press_o;
    end

    assign irq_o = |(irq_pending_o & irq_mask_i);

endmodule

// File: tb/tb_board_io_cond.sv
// Self-checking bench for board_io_cond against a sliding-window reference model.
module tb_board_io_cond;

    localparam int NB  = 2;
    localparam int NS  = 4;
    localparam int SS  = 2;
    localparam int DC  = 8;
    localparam int RH  = 4;
    localparam int NCH = NB + NS;
    localparam int L   = SS + DC;
    localparam int LL  = SS + RH;

    logic          clk = 1'b0;
    logic          arst = 1'b0;
    logic          pll_locked = 1'b1;
    logic [NB-1:0] btn = '0;
    logic [NS-1:0] sw = '0;
    logic [NB-1:0] mask = '0;
    logic [NB-1:0] ack = '0;

    logic          srst, irq, srst_nd, irq_nd;
    logic [NB-1:0] level, press, pend, level_nd, press_nd, pend_nd;
    logic [NS-1:0] swo, swo_nd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    board_io_cond #(
        .NUM_BTN(NB), .NUM_SW(NS), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
        .SW_DEBOUNCE(1'b1), .RST_HOLD_CYCLES(RH)
    ) u_dut (
        .clk_i(clk), .arst_i(arst), .pll_locked_i(pll_locked), .btn_i(btn), .sw_i(sw),
        .irq_mask_i(mask), .irq_ack_i(ack), .srst_o(srst), .btn_level_o(level),
        .btn_press_o(press), .irq_pending_o(pend), .irq_o(irq), .sw_o(swo)
    );

    board_io_cond #(
        .NUM_BTN(NB), .NUM_SW(NS), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
        .SW_DEBOUNCE(1'b0), .RST_HOLD_CYCLES(RH)
    ) u_dut_nd (
        .clk_i(clk), .arst_i(arst), .pll_locked_i(pll_locked), .btn_i(btn), .sw_i(sw),
        .irq_mask_i(mask), .irq_ack_i(ack), .srst_o(srst_nd), .btn_level_o(level_nd),
        .btn_press_o(press_nd), .irq_pending_o(pend_nd), .irq_o(irq_nd), .sw_o(swo_nd)
    );

    // Reference model: a level is accepted once the input, seen SS samples late,
    // has held one value for DC consecutive samples; reset releases once lock
    // has been seen for RH consecutive samples.
    logic [NCH-1:0] raw;
    assign raw = {sw, btn};

    bit [L-1:0]     hist [NCH];
    bit [LL-1:0]    lhist;
    bit [NCH-1:0]   m_level = '0;
    bit [NCH-1:0]   m_press = '0;
    bit [NB-1:0]    m_pend = '0;
    bit [NS-1:0]    m_swnd = '0;
    bit             m_srst = 1'b1;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int c = 0; c < NCH; c++) hist[c] = '0;
            lhist   = '0;
            m_level = '0;
            m_press = '0;
            m_pend  = '0;
            m_swnd  = '0;
            m_srst  = 1'b1;
        end else begin
            bit w, same;
            m_pend = (m_pend & ~ack) | m_press[NB-1:0];
            for (int c = 0; c < NCH; c++) begin
                w = hist[c][SS-1];
                same = 1'b1;
                for (int j = 0; j < DC; j++) if (hist[c][SS-1+j] != w) same = 1'b0;
                if (same && (w != m_level[c])) begin
                    m_level[c] = w;
                    m_press[c] = w;
                end else begin
                    m_press[c] = 1'b0;
                end
            end
            for (int s = 0; s < NS; s++) m_swnd[s] = hist[NB+s][SS-2];
            same = 1'b1;
            for (int j = 0; j < RH; j++) if (!lhist[SS-1+j]) same = 1'b0;
            m_srst = !same;
            for (int c = 0; c < NCH; c++) hist[c] = {hist[c][L-2:0], raw[c]};
            lhist = {lhist[LL-2:0], pll_locked};
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int fall;
        #2 arst = 1'b1;
        @(negedge clk);
        checks++; if (srst !== 1'b1) begin failures++; $display("FAIL rst_srst got %b want 1", srst); end
        checks++; if ({level, press, pend, irq, swo, swo_nd} !== '0) begin
            failures++; $display("FAIL rst_outputs got %b want 0", {level, press, pend, irq, swo, swo_nd});
        end
        arst = 1'b0;
        fall = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++; if (srst !== m_srst) begin failures++; $display("FAIL rel_srst edge %0d got %b want %b", k, srst, m_srst); end
            if (fall == 0 && srst === 1'b0) fall = k;
        end
        checks++; if (fall != 6) begin failures++; $display("FAIL rel_edge got %0d want 6", fall); end
    endtask

    task automatic test_lock_drop();
        int rise_e, fall;
        rise_e = 0;
        pll_locked = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (srst !== m_srst) begin failures++; $display("FAIL drop_srst edge %0d got %b want %b", k, srst, m_srst); end
            if (rise_e == 0 && srst === 1'b1) rise_e = k;
        end
        checks++; if (rise_e != 3) begin failures++; $display("FAIL drop_edge got %0d want 3", rise_e); end
        pll_locked = 1'b1;
        fall = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++; if (srst !== m_srst) begin failures++; $display("FAIL relock_srst edge %0d got %b want %b", k, srst, m_srst); end
            if (fall == 0 && srst === 1'b0) fall = k;
        end
        checks++; if (fall != 6) begin failures++; $display("FAIL relock_edge got %0d want 6", fall); end
    endtask

    task automatic test_clean_press();
        int pe, qe;
        pe = 0; qe = 0;
        mask = 2'b01;
        btn[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++; if ({level, press, pend} !== {m_level[NB-1:0], m_press[NB-1:0], m_pend}) begin
                failures++; $display("FAIL press_model edge %0d got %b want %b", k, {level, press, pend},
                                     {m_level[NB-1:0], m_press[NB-1:0], m_pend});
            end
            if (pe == 0 && press[0] === 1'b1) pe = k;
            if (qe == 0 && pend[0] === 1'b1) qe = k;
        end
        checks++; if (pe != 10) begin failures++; $display("FAIL press_edge got %0d want 10", pe); end
        checks++; if (qe != 11) begin failures++; $display("FAIL pend_edge got %0d want 11", qe); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL press_irq got %b want 1", irq); end
    endtask

    task automatic test_bounce();
        int pulses, pe;
        pulses = 0; pe = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc % 3 == 0) btn[1] = ~btn[1];
            tick();
            checks++; if (press[1] !== m_press[1]) begin failures++; $display("FAIL bounce_press cyc %0d got %b want %b", cyc, press[1], m_press[1]); end
            if (press[1] === 1'b1) pulses++;
        end
        btn[1] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            checks++; if (press[1] !== m_press[1]) begin failures++; $display("FAIL bounce_hold edge %0d got %b want %b", k, press[1], m_press[1]); end
            if (press[1] === 1'b1) begin pulses++; pe = k; end
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL bounce_pulses got %0d want 1", pulses); end
        checks++; if (pe != 10) begin failures++; $display("FAIL bounce_edge got %0d want 10", pe); end
    endtask

    task automatic test_ack_race();
        bit found;
        found = 1'b0;
        btn[0] = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        btn[0] = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_press[0]) begin
                ack[0] = 1'b1;
                found = 1'b1;
            end
            tick();
            ack[0] = 1'b0;
        end
        checks++; if (!found) begin failures++; $display("FAIL race_timeout got no press want press"); end
        checks++; if (pend[0] !== 1'b1 || pend !== m_pend) begin
            failures++; $display("FAIL race_pend got %b want %b", pend, m_pend);
        end
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        checks++; if (pend[0] !== 1'b0 || pend !== m_pend) begin failures++; $display("FAIL ack_clear got %b want %b", pend, m_pend); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ack_irq got %b want 0", irq); end
    endtask

    task automatic test_mask();
        btn[0] = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        btn[0] = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        checks++; if (pend !== 2'b11) begin failures++; $display("FAIL mask_pend got %b want 11", pend); end
        mask = 2'b00;
        #1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mask_off got %b want 0", irq); end
        mask = 2'b10;
        #1;
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mask_on got %b want 1", irq); end
    endtask

    task automatic test_switches();
        int e_nd, e_db;
        e_nd = 0; e_db = 0;
        sw = 4'hA;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++; if (swo !== m_level[NCH-1:NB] || swo_nd !== m_swnd) begin
                failures++; $display("FAIL sw_model edge %0d got %h/%h want %h/%h", k, swo, swo_nd, m_level[NCH-1:NB], m_swnd);
            end
            if (e_nd == 0 && swo_nd === 4'hA) e_nd = k;
            if (e_db == 0 && swo === 4'hA) e_db = k;
        end
        checks++; if (e_nd != 2) begin failures++; $display("FAIL sw_nd_edge got %0d want 2", e_nd); end
        checks++; if (e_db != 10) begin failures++; $display("FAIL sw_db_edge got %0d want 10", e_db); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            for (int b = 0; b < NB; b++) if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
            for (int s = 0; s < NS; s++) if ($urandom_range(0, 11) == 0) sw[s] = ~sw[s];
            ack  = NB'($urandom_range(0, 3)) & NB'($urandom_range(0, 3));
            mask = NB'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) pll_locked = ~pll_locked;
            tick();
            checks++; if ({srst, level, press, pend, irq, swo, swo_nd} !==
                          {m_srst, m_level[NB-1:0], m_press[NB-1:0], m_pend, |(m_pend & mask), m_level[NCH-1:NB], m_swnd}) begin
                failures++; $display("FAIL random cyc %0d got %b want %b", n, {srst, level, press, pend, irq, swo, swo_nd},
                    {m_srst, m_level[NB-1:0], m_press[NB-1:0], m_pend, |(m_pend & mask), m_level[NCH-1:NB], m_swnd});
            end
        end
        pll_locked = 1'b1;
        ack = '0;
    endtask

    task automatic test_arst_mid();
        sw = ~sw;
        btn = ~btn;
        for (int k = 0; k < 5; k++) tick();
        #2 arst = 1'b1;
        #1;
        checks++; if (srst !== 1'b1 || srst_nd !== 1'b1) begin failures++; $display("FAIL arst_srst got %b%b want 11", srst, srst_nd); end
        checks++; if ({level, press, pend, irq, swo, swo_nd} !== '0) begin
            failures++; $display("FAIL arst_outputs got %b want 0", {level, press, pend, irq, swo, swo_nd});
        end
        tick();
        arst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++; if ({srst, level, swo} !== {m_srst, m_level[NB-1:0], m_level[NCH-1:NB]}) begin
                failures++; $display("FAIL arst_recover edge %0d got %b want %b", k, {srst, level, swo},
                                     {m_srst, m_level[NB-1:0], m_level[NCH-1:NB]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_drop();
        test_clean_press();
        test_bounce();
        test_ack_race();
        test_mask();
        test_switches();
        test_random();
        test_arst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
